// File: rtl/accel_bus_bridge_if.sv
// CPU-side and accelerator-side handshake bundle for accel_bus_bridge.
// The slave modport is the bridge's view of the bundle; the master modport is the environment's.
interface accel_bus_bridge_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    logic            cpu_wr_en;
    logic [15:0]     cpu_wr_data;
    logic            cpu_rd_en;
    logic [15:0]     cpu_rd_data;
    logic            cpu_flush;
    logic            cpu_stall;
    logic            acc_cmd_valid;
    logic [15:0]     acc_cmd_data;
    logic            acc_cmd_ready;
    logic            acc_res_valid;
    logic [15:0]     acc_res_data;
    logic            acc_res_ready;
    logic [LvlW-1:0] tx_level;
    logic [LvlW-1:0] rx_level;

    modport slave (
        input  cpu_wr_en, cpu_wr_data, cpu_rd_en, cpu_flush,
        input  acc_cmd_ready, acc_res_valid, acc_res_data,
        output cpu_rd_data, cpu_stall, acc_cmd_valid, acc_cmd_data,
        output acc_res_ready, tx_level, rx_level
    );

    modport master (
        output cpu_wr_en, cpu_wr_data, cpu_rd_en, cpu_flush,
        output acc_cmd_ready, acc_res_valid, acc_res_data,
        input  cpu_rd_data, cpu_stall, acc_cmd_valid, acc_cmd_data,
        input  acc_res_ready, tx_level, rx_level
    );
endinterface

// File: rtl/accel_bus_bridge.sv
// CPU <-> accelerator bridge: a TX command FIFO and an RX result FIFO, both first-word-fall-through.
// The CPU is stalled when it writes into a full TX or reads from an empty RX.
module accel_bus_bridge #(
    parameter int unsigned DEPTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    accel_bus_bridge_if.slave  bus_io
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

    logic [15:0]     tx_mem_q [DEPTH];
    logic [15:0]     rx_mem_q [DEPTH];
    logic [PtrW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PtrW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [LvlW-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push, tx_pop, rx_push, rx_pop;

    assign tx_full  = (tx_lvl_q == LvlFull);
    assign tx_empty = (tx_lvl_q == '0);
    assign rx_full  = (rx_lvl_q == LvlFull);
    assign rx_empty = (rx_lvl_q == '0);

    // Push on a full FIFO is refused even if that cycle also pops.
    assign tx_push = bus_io.cpu_wr_en & ~tx_full;
    assign tx_pop  = bus_io.acc_cmd_ready & ~tx_empty;
    assign rx_push = bus_io.acc_res_valid & ~rx_full;
    assign rx_pop  = bus_io.cpu_rd_en & ~rx_empty;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_lvl_d  = tx_lvl_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_lvl_d  = rx_lvl_q;
        if (bus_io.cpu_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_lvl_d  = '0;
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_lvl_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + PtrW'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + PtrW'(1);
            if (rx_push) rx_wptr_d = rx_wptr_q + PtrW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + PtrW'(1);
            tx_lvl_d = tx_lvl_q + LvlW'(tx_push) - LvlW'(tx_pop);
            rx_lvl_d = rx_lvl_q + LvlW'(rx_push) - LvlW'(rx_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_lvl_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_lvl_q  <= '0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_lvl_q  <= tx_lvl_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_lvl_q  <= rx_lvl_d;
        end
    end

    // Storage is not reset; stale words are never visible because the levels gate the outputs.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= bus_io.cpu_wr_data;
        if (rx_push) rx_mem_q[rx_wptr_q] <= bus_io.acc_res_data;
    end

    assign bus_io.acc_cmd_valid = ~tx_empty;
    assign bus_io.acc_cmd_data  = tx_empty ? 16'h0000 : tx_mem_q[tx_rptr_q];
    assign bus_io.cpu_rd_data   = rx_empty ? 16'h0000 : rx_mem_q[rx_rptr_q];
    assign bus_io.acc_res_ready = ~rx_full;
    assign bus_io.cpu_stall     = (bus_io.cpu_wr_en & tx_full) | (bus_io.cpu_rd_en & rx_empty);
    assign bus_io.tx_level      = tx_lvl_q;
    assign bus_io.rx_level      = rx_lvl_q;
endmodule

// File: tb/tb_accel_bus_bridge.sv
// Bench for accel_bus_bridge: directed scenarios plus a randomized run checked against
// queue-based FIFO models.
module tb_accel_bus_bridge;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];

    accel_bus_bridge_if #(.DEPTH(DEPTH)) bif ();

    accel_bus_bridge #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bif.cpu_wr_en     = 1'b0;
        bif.cpu_wr_data   = 16'h0000;
        bif.cpu_rd_en     = 1'b0;
        bif.cpu_flush     = 1'b0;
        bif.acc_cmd_ready = 1'b0;
        bif.acc_res_valid = 1'b0;
        bif.acc_res_data  = 16'h0000;
    endtask

    // Apply the current inputs to the FIFO models, then move to just after the next edge.
    task automatic advance();
        bit tpush, tpop, rpush, rpop, fl;
        logic [15:0] wd, rd;
        tpop  = (tx_q.size() != 0) && bif.acc_cmd_ready;
        tpush = bif.cpu_wr_en && (tx_q.size() < DEPTH);
        rpop  = bif.cpu_rd_en && (rx_q.size() != 0);
        rpush = bif.acc_res_valid && (rx_q.size() < DEPTH);
        fl    = bif.cpu_flush;
        wd    = bif.cpu_wr_data;
        rd    = bif.acc_res_data;
        if (fl) begin
            tx_q.delete();
            rx_q.delete();
        end else begin
            if (tpop)  void'(tx_q.pop_front());
            if (tpush) tx_q.push_back(wd);
            if (rpop)  void'(rx_q.pop_front());
            if (rpush) rx_q.push_back(rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tx_q.delete();
        rx_q.delete();
        #12;
        total++;
        if (bif.tx_level !== 4'd0 || bif.rx_level !== 4'd0) begin
            bad++;
            $display("FAIL reset_levels: tx=%0d rx=%0d required 0 0", bif.tx_level, bif.rx_level);
        end
        total++;
        if (bif.acc_cmd_valid !== 1'b0 || bif.acc_cmd_data !== 16'h0000
            || bif.cpu_rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b cmd=%h rd=%h required 0 0000 0000",
                     bif.acc_cmd_valid, bif.acc_cmd_data, bif.cpu_rd_data);
        end
        total++;
        if (bif.acc_res_ready !== 1'b1 || bif.cpu_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_stall: ready=%b stall=%b required 1 0",
                     bif.acc_res_ready, bif.cpu_stall);
        end
        bif.cpu_rd_en = 1'b1;
        #1;
        total++;
        if (bif.cpu_stall !== 1'b1) begin
            bad++;
            $display("FAIL reset_rd_stall: stall=%b required 1", bif.cpu_stall);
        end
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_basic();
        bif.acc_cmd_ready = 1'b1;
        bif.cpu_wr_en     = 1'b1;
        bif.cpu_wr_data   = 16'h1234;
        #2;
        total++;
        if (bif.acc_cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_empty_valid: got %b required 0", bif.acc_cmd_valid);
        end
        advance();
        bif.cpu_wr_data = 16'hABCD;
        #2;
        total++;
        if (bif.acc_cmd_valid !== 1'b1 || bif.acc_cmd_data !== 16'h1234) begin
            bad++;
            $display("FAIL basic_first: valid=%b data=%h required 1 1234",
                     bif.acc_cmd_valid, bif.acc_cmd_data);
        end
        advance();
        bif.cpu_wr_en = 1'b0;
        #2;
        total++;
        if (bif.acc_cmd_valid !== 1'b1 || bif.acc_cmd_data !== 16'hABCD) begin
            bad++;
            $display("FAIL basic_second: valid=%b data=%h required 1 abcd",
                     bif.acc_cmd_valid, bif.acc_cmd_data);
        end
        advance();
        #2;
        total++;
        if (bif.tx_level !== 4'd0 || bif.acc_cmd_data !== 16'h0000) begin
            bad++;
            $display("FAIL basic_drained: level=%0d data=%h required 0 0000",
                     bif.tx_level, bif.acc_cmd_data);
        end
        idle();
    endtask

    task automatic test_tx_full();
        int n;
        idle();
        for (int i = 0; i < 9; i++) begin
            bif.cpu_wr_en   = 1'b1;
            bif.cpu_wr_data = 16'h0100 + 16'(i);
            #2;
            if (i == 8) begin
                total++;
                if (bif.tx_level !== 4'd8 || bif.cpu_stall !== 1'b1) begin
                    bad++;
                    $display("FAIL txfull_stall: level=%0d stall=%b required 8 1",
                             bif.tx_level, bif.cpu_stall);
                end
            end
            advance();
        end
        bif.acc_cmd_ready = 1'b1;
        #2;
        total++;
        if (bif.cpu_stall !== 1'b1 || bif.acc_cmd_data !== 16'h0100) begin
            bad++;
            $display("FAIL txfull_pop_blocked: stall=%b data=%h required 1 0100",
                     bif.cpu_stall, bif.acc_cmd_data);
        end
        advance();
        #2;
        total++;
        if (bif.tx_level !== 4'd7 || bif.cpu_stall !== 1'b0 || bif.acc_cmd_data !== 16'h0101) begin
            bad++;
            $display("FAIL txfull_after_pop: level=%0d stall=%b data=%h required 7 0 0101",
                     bif.tx_level, bif.cpu_stall, bif.acc_cmd_data);
        end
        advance();
        bif.cpu_wr_en = 1'b0;
        n = 2;
        for (int k = 0; k < 20 && bif.acc_cmd_valid === 1'b1; k++) begin
            #2;
            total++;
            if (bif.acc_cmd_data !== 16'h0100 + 16'(n)) begin
                bad++;
                $display("FAIL txfull_order: got %h required %h",
                         bif.acc_cmd_data, 16'h0100 + 16'(n));
            end
            n++;
            advance();
        end
        total++;
        if (n !== 9 || bif.tx_level !== 4'd0) begin
            bad++;
            $display("FAIL txfull_count: delivered up to %0d level=%0d required 9 0",
                     n, bif.tx_level);
        end
        idle();
    endtask

    task automatic test_rx_full();
        idle();
        for (int i = 0; i < 8; i++) begin
            bif.acc_res_valid = 1'b1;
            bif.acc_res_data  = 16'h00A0 + 16'(i);
            advance();
        end
        bif.acc_res_data = 16'h00A8;
        #2;
        total++;
        if (bif.rx_level !== 4'd8 || bif.acc_res_ready !== 1'b0) begin
            bad++;
            $display("FAIL rxfull_ready: level=%0d ready=%b required 8 0",
                     bif.rx_level, bif.acc_res_ready);
        end
        advance();
        bif.cpu_rd_en = 1'b1;
        #2;
        total++;
        if (bif.rx_level !== 4'd8 || bif.cpu_rd_data !== 16'h00A0 || bif.cpu_stall !== 1'b0) begin
            bad++;
            $display("FAIL rxfull_held: level=%0d rd=%h stall=%b required 8 00a0 0",
                     bif.rx_level, bif.cpu_rd_data, bif.cpu_stall);
        end
        advance();
        bif.cpu_rd_en = 1'b0;
        #2;
        total++;
        if (bif.rx_level !== 4'd7 || bif.acc_res_ready !== 1'b1) begin
            bad++;
            $display("FAIL rxfull_after_pop: level=%0d ready=%b required 7 1",
                     bif.rx_level, bif.acc_res_ready);
        end
        advance();
        bif.acc_res_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bif.cpu_rd_en = 1'b1;
            #2;
            total++;
            if (bif.cpu_rd_data !== 16'h00A0 + 16'(k)) begin
                bad++;
                $display("FAIL rxfull_order: got %h required %h",
                         bif.cpu_rd_data, 16'h00A0 + 16'(k));
            end
            advance();
        end
        idle();
        #2;
        total++;
        if (bif.rx_level !== 4'd0) begin
            bad++;
            $display("FAIL rxfull_drained: level=%0d required 0", bif.rx_level);
        end
    endtask

    task automatic test_rd_empty();
        idle();
        bif.cpu_rd_en = 1'b1;
        #2;
        total++;
        if (bif.cpu_stall !== 1'b1 || bif.cpu_rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL rdempty_stall: stall=%b rd=%h required 1 0000",
                     bif.cpu_stall, bif.cpu_rd_data);
        end
        bif.acc_res_valid = 1'b1;
        bif.acc_res_data  = 16'h00FF;
        advance();
        bif.acc_res_valid = 1'b0;
        #2;
        total++;
        if (bif.cpu_stall !== 1'b0 || bif.cpu_rd_data !== 16'h00FF || bif.rx_level !== 4'd1) begin
            bad++;
            $display("FAIL rdempty_arrival: stall=%b rd=%h level=%0d required 0 00ff 1",
                     bif.cpu_stall, bif.cpu_rd_data, bif.rx_level);
        end
        advance();
        idle();
        #2;
        total++;
        if (bif.rx_level !== 4'd0) begin
            bad++;
            $display("FAIL rdempty_popped: level=%0d required 0", bif.rx_level);
        end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 5; i++) begin
            bif.cpu_wr_en     = 1'b1;
            bif.cpu_wr_data   = 16'h0500 + 16'(i);
            bif.acc_res_valid = (i < 2);
            bif.acc_res_data  = 16'h0600 + 16'(i);
            advance();
        end
        bif.acc_res_valid = 1'b0;
        bif.cpu_flush     = 1'b1;
        bif.cpu_wr_data   = 16'h0EEE;
        #2;
        total++;
        if (bif.tx_level !== 4'd5 || bif.rx_level !== 4'd2) begin
            bad++;
            $display("FAIL flush_pre: tx=%0d rx=%0d required 5 2", bif.tx_level, bif.rx_level);
        end
        advance();
        idle();
        #2;
        total++;
        if (bif.tx_level !== 4'd0 || bif.rx_level !== 4'd0 || bif.acc_cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_post: tx=%0d rx=%0d valid=%b required 0 0 0",
                     bif.tx_level, bif.rx_level, bif.acc_cmd_valid);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            bif.cpu_wr_en     = 1'b1;
            bif.cpu_wr_data   = 16'h0700 + 16'(i);
            bif.acc_res_valid = (i < 2);
            bif.acc_res_data  = 16'h0800 + 16'(i);
            advance();
        end
        idle();
        #2;
        rst_n = 1'b0;
        tx_q.delete();
        rx_q.delete();
        #1;
        total++;
        if (bif.tx_level !== 4'd0 || bif.rx_level !== 4'd0 || bif.acc_cmd_valid !== 1'b0
            || bif.acc_res_ready !== 1'b1 || bif.acc_cmd_data !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_async: tx=%0d rx=%0d valid=%b ready=%b cmd=%h req 0 0 0 1 0000",
                     bif.tx_level, bif.rx_level, bif.acc_cmd_valid, bif.acc_res_ready,
                     bif.acc_cmd_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bif.acc_cmd_ready = 1'b1;
        #2;
        total++;
        if (bif.acc_cmd_valid !== 1'b0 || bif.cpu_rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_release: valid=%b rd=%h required 0 0000",
                     bif.acc_cmd_valid, bif.cpu_rd_data);
        end
        advance();
        idle();
    endtask

    task automatic test_random();
        logic [15:0] e_cmd, e_rd;
        logic e_valid, e_ready, e_stall;
        int e_tx, e_rx;
        idle();
        for (int c = 0; c < 600; c++) begin
            bif.cpu_wr_en     = ($urandom_range(0, 99) < 55);
            bif.cpu_wr_data   = 16'($urandom);
            bif.cpu_rd_en     = ($urandom_range(0, 99) < 45);
            bif.cpu_flush     = ($urandom_range(0, 63) == 0);
            bif.acc_cmd_ready = ($urandom_range(0, 99) < 45);
            bif.acc_res_valid = ($urandom_range(0, 99) < 55);
            bif.acc_res_data  = 16'($urandom);
            #2;
            e_tx    = tx_q.size();
            e_rx    = rx_q.size();
            e_valid = (e_tx != 0);
            e_cmd   = (e_tx != 0) ? tx_q[0] : 16'h0000;
            e_rd    = (e_rx != 0) ? rx_q[0] : 16'h0000;
            e_ready = (e_rx < DEPTH);
            e_stall = (bif.cpu_wr_en && e_tx == DEPTH) || (bif.cpu_rd_en && e_rx == 0);
            total++;
            if (bif.tx_level !== 4'(e_tx) || bif.rx_level !== 4'(e_rx)) begin
                bad++;
                $display("FAIL rand_levels c=%0d: tx=%0d rx=%0d required %0d %0d",
                         c, bif.tx_level, bif.rx_level, e_tx, e_rx);
            end
            total++;
            if (bif.acc_cmd_valid !== e_valid || bif.acc_cmd_data !== e_cmd) begin
                bad++;
                $display("FAIL rand_cmd c=%0d: valid=%b data=%h required %b %h",
                         c, bif.acc_cmd_valid, bif.acc_cmd_data, e_valid, e_cmd);
            end
            total++;
            if (bif.cpu_rd_data !== e_rd || bif.acc_res_ready !== e_ready) begin
                bad++;
                $display("FAIL rand_rx c=%0d: rd=%h ready=%b required %h %b",
                         c, bif.cpu_rd_data, bif.acc_res_ready, e_rd, e_ready);
            end
            total++;
            if (bif.cpu_stall !== e_stall) begin
                bad++;
                $display("FAIL rand_stall c=%0d: stall=%b required %b", c, bif.cpu_stall, e_stall);
            end
            advance();
        end
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        test_reset();
        test_basic();
        test_tx_full();
        test_rx_full();
        test_rd_empty();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accel_bus_bridge.md
ACCEL_BUS_BRIDGE -- requirements
Module: accel_bus_bridge

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_wr_en  input  1  CPU bus write strobe; push cpu_wr_data to TX FIFO.
REQ-005 cpu_wr_data  input  16  command/operand word to accelerator.
REQ-006 cpu_rd_en  input  1  CPU bus read strobe; pop RX FIFO head.
REQ-007 cpu_rd_data  output  16  RX FIFO head word.
REQ-008 cpu_flush  input  1  synchronous clear of both FIFOs.
REQ-009 cpu_stall  output  1  CPU must hold its current bus operation.
REQ-010 acc_cmd_valid  output  1  TX head word valid toward accelerator.
REQ-011 acc_cmd_data  output  16  TX head word.
REQ-012 acc_cmd_ready  input  1  accelerator accepts acc_cmd_data.
REQ-013 acc_res_valid  input  1  accelerator result word valid.
REQ-014 acc_res_data  input  16  accelerator result word.
REQ-015 acc_res_ready  output  1  bridge accepts acc_res_data.
REQ-016 tx_level  output  $clog2(DEPTH)+1  TX FIFO occupancy, 0..DEPTH.
REQ-017 rx_level  output  $clog2(DEPTH)+1  RX FIFO occupancy, 0..DEPTH.

Function
REQ-018 TX and RX SHALL each be DEPTH x 16 circular FIFOs: read/write pointers wrap modulo DEPTH; separate occupancy counter.
REQ-019 TX push SHALL occur when cpu_wr_en=1 and tx_level<DEPTH; the word is visible on acc_cmd_data on the next cycle if TX was empty.
REQ-020 acc_cmd_valid SHALL equal (tx_level!=0); acc_cmd_data SHALL be the TX head combinationally (first-word-fall-through), else 16'h0000.
REQ-021 TX pop SHALL occur when acc_cmd_valid & acc_cmd_ready; acc_cmd_data SHALL remain stable while valid and not ready.
REQ-022 acc_res_ready SHALL equal (rx_level<DEPTH); RX push SHALL occur when acc_res_valid & acc_res_ready.
REQ-023 cpu_rd_data SHALL be the RX head combinationally when rx_level!=0, else 16'h0000; RX pop occurs when cpu_rd_en=1 and rx_level!=0.
REQ-024 cpu_stall SHALL be combinational: (cpu_wr_en & tx_level==DEPTH) | (cpu_rd_en & rx_level==0).
REQ-025 Full FIFO: push is blocked even if a pop occurs in the same cycle; level stays DEPTH then drops to DEPTH-1.
REQ-026 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its level unchanged; both pointers advance.
REQ-027 Empty FIFO: pop is ignored; a same-cycle push makes the level 1 at the next edge.
REQ-028 cpu_wr_en and cpu_rd_en asserted together SHALL be handled independently on TX and RX.
REQ-029 cpu_flush=1 SHALL zero both pointers and levels at the next edge, overriding all pushes and pops that cycle; acc_cmd_valid is 0 on the following cycle.
REQ-030 Levels SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear all pointers and levels; FIFO storage need not be cleared.
REQ-032 During and after reset: acc_cmd_valid=0, acc_cmd_data=0, cpu_rd_data=0, tx_level=0, rx_level=0, acc_res_ready=1, cpu_stall follows REQ-024.
REQ-033 Reset mid-transfer SHALL discard all queued words; no partial word is delivered after reset release.

Verification
REQ-034 Write 16'h1234, 16'hABCD with acc_cmd_ready=1 -> acc_cmd_data shows 1234 then ABCD on consecutive cycles; tx_level returns to 0.
REQ-035 acc_cmd_ready=0, write 9 words with DEPTH=8 -> tx_level=8, cpu_stall=1 on the 9th write; ready=1 then the 9th word is accepted, order preserved.
REQ-036 Accelerator sends 8 results with no CPU reads -> acc_res_ready=0 at rx_level=8; the 9th result is held until cpu_rd_en pops.
REQ-037 cpu_rd_en with RX empty -> cpu_stall=1, cpu_rd_data=0; result 16'h00FF arrives -> cpu_stall=0 on the next cycle, cpu_rd_data=00FF.
REQ-038 TX holding 5 words, cpu_flush with cpu_wr_en in the same cycle -> tx_level=0 at the next edge, acc_cmd_valid=0.
REQ-039 rst_n pulsed low with 3 TX and 2 RX words queued -> all levels 0, acc_cmd_valid=0, acc_res_ready=1 immediately.
